stream_merge_rr: RTL and testbench

- Four-source to one-sink merge with round-robin arbitration; the return path of the 1-to-4 address router.
- Each source presents a valid/ready stream. The block grants one source per cycle, registers its word with the source index, and drives a single valid/ready output.
- Sits in front of a shared consumer, e.g. a common response bus fed by the four router outputs.

---
 rtl/router_pkg.sv | 14 +
 rtl/rr_arbiter4.sv | 54 +++++
 rtl/stream_merge_rr.sv | 94 +++++++++
 tb/tb_stream_merge_rr.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the 1-to-4 address router and its 4-to-1 return merge.
package router_pkg;

  localparam int NUM_PORTS = 4;
  localparam int ADDR_W    = $clog2(NUM_PORTS);

  typedef logic [ADDR_W-1:0] port_idx_t;

  // Next port index, wrapping modulo NUM_PORTS through the natural width of port_idx_t.
  function automatic port_idx_t next_idx(input port_idx_t idx);
    return idx + port_idx_t'(1'b1);
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: combinational grant searched from ptr, with a
// registered pointer that advances past the winner whenever the grant is taken.
module rr_arbiter4
  import router_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 take,
  output logic [NUM_PORTS-1:0] grant,
  output port_idx_t            grant_idx,
  output logic                 grant_valid
);

  port_idx_t            ptr_r;
  port_idx_t            idx_s;
  port_idx_t            grant_idx_s;
  logic [NUM_PORTS-1:0] grant_s;
  logic                 found_s;

  // First requester at or after ptr (wrapping) wins; one-hot grant plus its index.
  always_comb begin
    grant_s     = {NUM_PORTS{1'b0}};
    grant_idx_s = ptr_r;
    found_s     = 1'b0;
    idx_s       = ptr_r;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx_s = ptr_r + port_idx_t'(i);
      if (!found_s && req[idx_s]) begin
        grant_s[idx_s] = 1'b1;
        grant_idx_s    = idx_s;
        found_s        = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer moves to the port after the winner only when a transfer actually happens.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= {ADDR_W{1'b0}};
    end else if (take) begin
      ptr_r <= next_idx(grant_idx_s);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign grant       = grant_s;
  assign grant_idx   = grant_idx_s;
  assign grant_valid = found_s;

endmodule

// File: rtl/stream_merge_rr.sv
// Four-source round-robin stream merge with a single registered output stage.
// The output register refills in the same cycle it drains, so a continuously
// ready sink sees one word per cycle.
module stream_merge_rr
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [DATA_WIDTH-1:0] din2,
  input  logic [DATA_WIDTH-1:0] din3,
  input  logic [NUM_PORTS-1:0]  din_valid,
  output logic [NUM_PORTS-1:0]  din_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_W-1:0]     dout_addr,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  logic [DATA_WIDTH-1:0] dout_r;
  port_idx_t             dout_addr_r;
  logic                  dout_valid_r;

  logic                  can_accept_s;
  logic                  take_s;
  logic [NUM_PORTS-1:0]  grant_s;
  logic [NUM_PORTS-1:0]  din_ready_s;
  port_idx_t             grant_idx_s;
  logic                  grant_valid_s;
  logic [DATA_WIDTH-1:0] din_mux_s;

  rr_arbiter4 u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (din_valid),
    .take        (take_s),
    .grant       (grant_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_valid_s)
  );

  // Accept when the output register is empty or draining; never during reset.
  always_comb begin
    can_accept_s = !dout_valid_r || dout_ready;
    if (reset) begin
      din_ready_s = {NUM_PORTS{1'b0}};
    end else begin
      din_ready_s = grant_s & {NUM_PORTS{can_accept_s & grant_valid_s}};
    end
    take_s = |(din_ready_s & din_valid);
  end

  // Select the granted source's word; data only feeds the register, never din_ready.
  always_comb begin
    din_mux_s = din0;
    case (grant_idx_s)
      2'd0:    din_mux_s = din0;
      2'd1:    din_mux_s = din1;
      2'd2:    din_mux_s = din2;
      2'd3:    din_mux_s = din3;
      default: din_mux_s = din0;
    endcase
  end

  // Output register: load on transfer, clear valid when drained, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_r       <= {DATA_WIDTH{1'b0}};
      dout_addr_r  <= {ADDR_W{1'b0}};
      dout_valid_r <= 1'b0;
    end else if (take_s) begin
      dout_r       <= din_mux_s;
      dout_addr_r  <= grant_idx_s;
      dout_valid_r <= 1'b1;
    end else if (dout_ready) begin
      dout_r       <= dout_r;
      dout_addr_r  <= dout_addr_r;
      dout_valid_r <= 1'b0;
    end else begin
      dout_r       <= dout_r;
      dout_addr_r  <= dout_addr_r;
      dout_valid_r <= dout_valid_r;
    end
  end

  assign din_ready  = din_ready_s;
  assign dout       = dout_r;
  assign dout_addr  = dout_addr_r;
  assign dout_valid = dout_valid_r;

endmodule

// File: tb/tb_stream_merge_rr.sv
// Bench for stream_merge_rr: directed scenarios with literal expectations, then
// randomized protocol-respecting traffic, all compared every cycle against a
// transaction-level model of the merge.
module tb_stream_merge_rr;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] din [4];
  logic [3:0]  din_valid = 4'b0000;
  logic [3:0]  din_ready;
  logic [31:0] dout;
  logic [1:0]  dout_addr;
  logic        dout_valid;
  logic        dout_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: output register contents and the round-robin pointer.
  int          m_ptr;
  bit          m_valid;
  logic [31:0] m_data;
  int          m_addr;

  stream_merge_rr #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .din0       (din[0]),
    .din1       (din[1]),
    .din2       (din[2]),
    .din3       (din[3]),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_addr  (dout_addr),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Which source the model would grant now, or -1 when none is requesting.
  function automatic int model_grant();
    for (int i = 0; i < 4; i++) begin
      if (din_valid[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int g;
    logic [3:0] r;
    r = 4'b0000;
    g = model_grant();
    if (!reset && (!m_valid || dout_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  // Model advances on the same edge as the DUT using the pre-edge inputs.
  always @(posedge clk or posedge reset) begin
    int g;
    if (reset) begin
      m_ptr = 0; m_valid = 1'b0; m_data = 32'd0; m_addr = 0;
    end else begin
      g = model_grant();
      if ((!m_valid || dout_ready) && g >= 0) begin
        m_data  = din[g];
        m_addr  = g;
        m_valid = 1'b1;
        m_ptr   = (g + 1) % 4;
      end else if (dout_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("din_ready", {28'd0, din_ready}, {28'd0, model_ready()});
      check("dout_valid", {31'd0, dout_valid}, {31'd0, m_valid});
      check("dout_addr", {30'd0, dout_addr}, m_addr);
      check("dout", dout, m_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] acc;

  initial begin
    for (int k = 0; k < 4; k++) din[k] = 32'hD000_0000 + k;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    cyc();
    reset = 1'b0;

    // Idle after reset.
    dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1;
      check("idle_valid", {31'd0, dout_valid}, 32'd0);
      check("idle_ready", {28'd0, din_ready}, 32'd0);
      check("idle_dout", dout, 32'd0);
      check("idle_addr", {30'd0, dout_addr}, 32'd0);
    end

    // Single source 2.
    din_valid = 4'b0100;
    din[2] = 32'hA5A5_0002;
    #1 check("single_ready", {28'd0, din_ready}, 32'h4);
    cyc();
    din_valid = 4'b0000;
    #1;
    check("single_dout", dout, 32'hA5A5_0002);
    check("single_addr", {30'd0, dout_addr}, 32'd2);
    check("single_valid", {31'd0, dout_valid}, 32'd1);
    check("model_ptr_single", m_ptr, 32'd3);

    // ptr=3 with all valid: source 3 wins, pointer wraps to 0.
    din[2] = 32'hD000_0002;
    din_valid = 4'b1111;
    #1 check("wrap_ready3", {28'd0, din_ready}, 32'h8);
    cyc();
    #1 check("wrap_addr3", {30'd0, dout_addr}, 32'd3);

    // All valid continuously from ptr=0: 0,1,2,3,0,1,2,3 back to back.
    for (int i = 0; i < 8; i++) begin
      check("rr_ready", {28'd0, din_ready}, 32'd1 << (i % 4));
      cyc();
      #1;
      check("rr_addr", {30'd0, dout_addr}, i % 4);
      check("rr_valid", {31'd0, dout_valid}, 32'd1);
      check("rr_dout", dout, 32'hD000_0000 + (i % 4));
    end
    check("model_ptr_rr", m_ptr, 32'd0);

    // Backpressure: first word from 0, then stall for 3 cycles.
    cyc();
    #1 check("bp_first", {30'd0, dout_addr}, 32'd0);
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_ready", {28'd0, din_ready}, 32'd0);
      cyc();
      #1;
      check("bp_addr", {30'd0, dout_addr}, 32'd0);
      check("bp_dout", dout, 32'hD000_0000);
    end
    dout_ready = 1'b1;
    #1 check("bp_resume", {28'd0, din_ready}, 32'h2);
    cyc();

    // Sparse wrap: reach ptr=3 via source 2, then 0011 grants 0 then 1.
    din_valid = 4'b0100;
    cyc();
    din_valid = 4'b0011;
    #1 check("sparse_r0", {28'd0, din_ready}, 32'h1);
    cyc();
    #1 check("sparse_r1", {28'd0, din_ready}, 32'h2);
    cyc();
    #1 check("sparse_addr1", {30'd0, dout_addr}, 32'd1);
    din_valid = 4'b0100;
    cyc();
    din_valid = 4'b1000;
    #1 check("sparse_r3", {28'd0, din_ready}, 32'h8);
    cyc();
    din_valid = 4'b1111;
    #1 check("sparse_ptr0", {28'd0, din_ready}, 32'h1);

    // Async reset mid-cycle while the output register is full.
    check("pre_rst_valid", {31'd0, dout_valid}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_ready", {28'd0, din_ready}, 32'd0);
    cyc();
    cyc();
    reset = 1'b0;
    #1 check("post_rst_ready", {28'd0, din_ready}, 32'h1);
    cyc();
    #1 check("post_rst_addr", {30'd0, dout_addr}, 32'd0);

    // Random traffic: sources hold data/valid until accepted.
    acc = din_valid & din_ready;
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (reset) reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (acc[k] || !din_valid[k]) begin
          din_valid[k] = ($urandom_range(0, 9) < 6);
          din[k] = $urandom;
        end
      end
      dout_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 499) == 0) reset = 1'b1;
      #1;
      acc = din_valid & din_ready;
    end

    cyc();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
